// File: rtl/quant_port_scheduler_pkg.sv
// quant_port_scheduler shared types and helpers.
// Tag entry layout, default sizing and the round-robin pick function.
package quant_sched_pkg;

  localparam int DEF_SRAMC_W     = 128;
  localparam int DEF_ADRC_W      = 11;
  localparam int DEF_SRAMC_N     = 8;
  localparam int DEF_N_REQ       = 2;
  localparam int DEF_PIPE_LAT    = 6;
  localparam int DEF_SRAM_RD_LAT = 1;
  localparam int TAG_DEPTH       = 1 + DEF_PIPE_LAT + DEF_SRAM_RD_LAT;
  localparam int MAX_REQ         = 8;
  localparam int ID_W            = 3;

  typedef struct packed {
    logic            vld;
    logic            is_rd;
    logic [ID_W-1:0] id;
  } tag_t;

  // First set bit of valid after ptr, wrapping at n.
  function automatic logic [MAX_REQ-1:0] rr_pick(
    input logic [MAX_REQ-1:0] valid,
    input logic [ID_W-1:0]    ptr,
    input int                 n
  );
    logic [MAX_REQ-1:0] g;
    logic               found;
    int                 idx;
    g     = '0;
    found = 1'b0;
    for (int i = 1; i <= MAX_REQ; i++) begin
      idx = (int'(ptr) + i) % n;
      if (i <= n && !found && valid[idx[2:0]]) begin
        g[idx[2:0]] = 1'b1;
        found       = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/quant_port_scheduler_if.sv
// quant_port_scheduler bus interface.
// master = requesters/SRAM side, slave = scheduler.
interface quant_port_scheduler_if
  import quant_sched_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int SRAMC_W = DEF_SRAMC_W,
  parameter int ADRC_W  = DEF_ADRC_W,
  parameter int SRAMC_N = DEF_SRAMC_N
);
  logic                       i_hold;
  logic [N_REQ-1:0]           i_req_valid;
  logic [N_REQ-1:0]           o_req_ready;
  logic [N_REQ-1:0]           i_req_we;
  logic [N_REQ*ADRC_W-1:0]    i_req_addr;
  logic [N_REQ*SRAMC_W-1:0]   i_req_wdata;
  logic [N_REQ*SRAMC_N-1:0]   i_req_wmask;
  logic [SRAMC_W-1:0]         o_sramc_wdata_q;
  logic [ADRC_W-1:0]          o_sramc_addr_q;
  logic                       o_sramc_wren_q;
  logic [SRAMC_N-1:0]         o_sramc_wmask_q;
  logic                       o_sramc_rden_q;
  logic [SRAMC_W-1:0]         i_sramc_rdata;
  logic [N_REQ-1:0]           o_rsp_valid;
  logic [SRAMC_W-1:0]         o_rsp_rdata;
  logic                       o_idle;
  logic [15:0]                o_hazard_cnt;

  modport master (
    output i_hold, i_req_valid, i_req_we,
    output i_req_addr, i_req_wdata, i_req_wmask,
    output i_sramc_rdata,
    input  o_req_ready, o_sramc_wdata_q, o_sramc_addr_q,
    input  o_sramc_wren_q, o_sramc_wmask_q, o_sramc_rden_q,
    input  o_rsp_valid, o_rsp_rdata, o_idle, o_hazard_cnt
  );

  modport slave (
    input  i_hold, i_req_valid, i_req_we,
    input  i_req_addr, i_req_wdata, i_req_wmask,
    input  i_sramc_rdata,
    output o_req_ready, o_sramc_wdata_q, o_sramc_addr_q,
    output o_sramc_wren_q, o_sramc_wmask_q, o_sramc_rden_q,
    output o_rsp_valid, o_rsp_rdata, o_idle, o_hazard_cnt
  );
endinterface

// File: rtl/quant_port_scheduler_rr_arb.sv
// quant_sched_rr_arb: N-way round-robin arbiter.
// Grant goes to the first requester after ptr; en=0 masks all grants.
module quant_sched_rr_arb
  import quant_sched_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  input  logic            en,
  output logic [N-1:0]    gnt
);
  logic [MAX_REQ-1:0] pick;

  // One-hot pick, gated by enable
  always_comb begin
    pick = rr_pick(MAX_REQ'(req), ptr, N);
    gnt  = en ? pick[N-1:0] : '0;
  end

  if (N < MAX_REQ) begin : g_unused
    logic unused_hi;
    assign unused_hi = |pick[MAX_REQ-1:N];
  end
endmodule

// File: rtl/quant_port_scheduler.sv
// quant_port_scheduler: round-robin owner of the quantized SRAMC port.
// Optional macro QUANT_SCHED_HAZARD_CNT_EN enables the hold-stall counter.
module quant_port_scheduler
  import quant_sched_pkg::*;
#(
  parameter int SRAMC_W     = DEF_SRAMC_W,
  parameter int ADRC_W      = DEF_ADRC_W,
  parameter int SRAMC_N     = DEF_SRAMC_N,
  parameter int N_REQ       = DEF_N_REQ,
  parameter int PIPE_LAT    = DEF_PIPE_LAT,
  parameter int SRAM_RD_LAT = DEF_SRAM_RD_LAT
) (
  input logic                  i_clk,
  input logic                  i_rst,
  quant_port_scheduler_if.slave bus
);
  localparam int D = 1 + PIPE_LAT + SRAM_RD_LAT;

  logic [N_REQ-1:0]   gnt;
  logic               arb_en;
  logic               accept;
  logic [ID_W-1:0]    gnt_id;
  logic               sel_we;
  logic [ADRC_W-1:0]  sel_addr;
  logic [SRAMC_W-1:0] sel_wdata;
  logic [SRAMC_N-1:0] sel_wmask;

  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic               wren_q, wren_d;
  logic               rden_q, rden_d;
  logic [ADRC_W-1:0]  addr_q, addr_d;
  logic [SRAMC_W-1:0] wdata_q, wdata_d;
  logic [SRAMC_N-1:0] wmask_q, wmask_d;
  tag_t               tag_q [D];
  tag_t               tag_d [D];
  logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [SRAMC_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic               busy;

  assign arb_en = ~bus.i_hold & ~i_rst;

  quant_sched_rr_arb #(.N(N_REQ)) u_arb (
    .req (bus.i_req_valid),
    .ptr (ptr_q),
    .en  (arb_en),
    .gnt (gnt)
  );

  // Encode the grant and select the winning payload
  always_comb begin
    gnt_id    = '0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wmask = '0;
    for (int r = 0; r < N_REQ; r++) begin
      if (gnt[r]) begin
        gnt_id    = ID_W'(r);
        sel_we    = bus.i_req_we[r];
        sel_addr  = bus.i_req_addr[r*ADRC_W +: ADRC_W];
        sel_wdata = bus.i_req_wdata[r*SRAMC_W +: SRAMC_W];
        sel_wmask = bus.i_req_wmask[r*SRAMC_N +: SRAMC_N];
      end
    end
    accept = |gnt;
  end

  // Next state: pointer, issue regs, tag shift, response
  always_comb begin
    ptr_d   = accept ? gnt_id : ptr_q;
    wren_d  = accept & sel_we;
    rden_d  = accept & ~sel_we;
    addr_d  = accept ? sel_addr  : addr_q;
    wdata_d = accept ? sel_wdata : wdata_q;
    wmask_d = accept ? sel_wmask : wmask_q;
    tag_d[0] = '{vld: accept, is_rd: ~sel_we, id: gnt_id};
    for (int i = 1; i < D; i++) begin
      tag_d[i] = tag_q[i-1];
    end
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    if (tag_q[D-1].vld && tag_q[D-1].is_rd) begin
      rsp_rdata_d = bus.i_sramc_rdata;
      for (int r = 0; r < N_REQ; r++) begin
        if (tag_q[D-1].id == ID_W'(r)) rsp_valid_d[r] = 1'b1;
      end
    end
  end

  // Idle when nothing is in the tag pipe and nothing issues now
  always_comb begin
    busy = accept;
    for (int i = 0; i < D; i++) begin
      busy = busy | tag_q[i].vld;
    end
  end

  // State registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr_q       <= ID_W'(N_REQ - 1);
      wren_q      <= 1'b0;
      rden_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      for (int i = 0; i < D; i++) tag_q[i] <= '0;
    end else begin
      ptr_q       <= ptr_d;
      wren_q      <= wren_d;
      rden_q      <= rden_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      for (int i = 0; i < D; i++) tag_q[i] <= tag_d[i];
    end
  end

`ifdef QUANT_SCHED_HAZARD_CNT_EN
  logic [15:0] hz_q, hz_d;

  // Saturating count of cycles stalled by hold
  always_comb begin
    hz_d = hz_q;
    if ((|bus.i_req_valid) && bus.i_hold && !accept && hz_q != 16'hFFFF)
      hz_d = hz_q + 16'd1;
  end

  // Hazard counter register
  always_ff @(posedge i_clk) begin
    if (i_rst) hz_q <= '0;
    else       hz_q <= hz_d;
  end

  assign bus.o_hazard_cnt = hz_q;
`else
  assign bus.o_hazard_cnt = '0;
`endif

  assign bus.o_req_ready     = gnt;
  assign bus.o_sramc_wren_q  = wren_q;
  assign bus.o_sramc_rden_q  = rden_q;
  assign bus.o_sramc_addr_q  = addr_q;
  assign bus.o_sramc_wdata_q = wdata_q;
  assign bus.o_sramc_wmask_q = wmask_q;
  assign bus.o_rsp_valid     = rsp_valid_q;
  assign bus.o_rsp_rdata     = rsp_rdata_q;
  assign bus.o_idle          = ~busy;
endmodule

// File: tb/tb_quant_port_scheduler.sv
// tb_quant_port_scheduler: directed scenarios plus randomized traffic
// checked against a transaction-level model of the scheduler.
module tb_quant_port_scheduler;
  localparam int N  = 2;
  localparam int AW = 11;
  localparam int DW = 128;
  localparam int MW = 8;
  localparam int D  = 8;
`ifdef QUANT_SCHED_HAZARD_CNT_EN
  localparam bit HZ_EN = 1'b1;
`else
  localparam bit HZ_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  quant_port_scheduler_if #(
    .N_REQ(N), .SRAMC_W(DW), .ADRC_W(AW), .SRAMC_N(MW)
  ) bus ();

  quant_port_scheduler #(
    .SRAMC_W(DW), .ADRC_W(AW), .SRAMC_N(MW),
    .N_REQ(N), .PIPE_LAT(6), .SRAM_RD_LAT(1)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [DW-1:0] hist [int];
  logic [DW-1:0] rd_val;

  typedef struct { int due; int id; } rsp_t;

  always @(posedge clk) cyc <= cyc + 1;

  // fresh SRAM read data every cycle, remembered per cycle
  always @(negedge clk) begin
    rd_val = {$urandom, $urandom, $urandom, $urandom};
    bus.i_sramc_rdata = rd_val;
    hist[cyc] = rd_val;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  function automatic logic [N-1:0] ref_pick(logic [N-1:0] v, int ptr);
    for (int k = 1; k <= N; k++) begin
      if (v[(ptr + k) % N]) return N'(1) << ((ptr + k) % N);
    end
    return '0;
  endfunction

  task automatic idle_inputs();
    bus.i_hold      = 1'b0;
    bus.i_req_valid = '0;
    bus.i_req_we    = '0;
    bus.i_req_addr  = '0;
    bus.i_req_wdata = '0;
    bus.i_req_wmask = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    bus.i_req_valid = '1;
    #1;
    n_cmp++; if (bus.o_req_ready !== 2'b00) begin n_bad++; $display("FAIL rst_ready got=%b exp=00", bus.o_req_ready); end
    @(negedge clk);
    #1;
    n_cmp++; if (bus.o_sramc_wren_q !== 1'b0) begin n_bad++; $display("FAIL rst_wren got=%b exp=0", bus.o_sramc_wren_q); end
    n_cmp++; if (bus.o_sramc_rden_q !== 1'b0) begin n_bad++; $display("FAIL rst_rden got=%b exp=0", bus.o_sramc_rden_q); end
    n_cmp++; if (bus.o_sramc_addr_q !== '0) begin n_bad++; $display("FAIL rst_addr got=%h exp=0", bus.o_sramc_addr_q); end
    n_cmp++; if (bus.o_sramc_wdata_q !== '0) begin n_bad++; $display("FAIL rst_wdata got=%h exp=0", bus.o_sramc_wdata_q); end
    n_cmp++; if (bus.o_sramc_wmask_q !== '0) begin n_bad++; $display("FAIL rst_wmask got=%h exp=0", bus.o_sramc_wmask_q); end
    n_cmp++; if (bus.o_rsp_valid !== '0) begin n_bad++; $display("FAIL rst_rspv got=%b exp=0", bus.o_rsp_valid); end
    n_cmp++; if (bus.o_rsp_rdata !== '0) begin n_bad++; $display("FAIL rst_rdata got=%h exp=0", bus.o_rsp_rdata); end
    n_cmp++; if (bus.o_idle !== 1'b1) begin n_bad++; $display("FAIL rst_idle got=%b exp=1", bus.o_idle); end
    n_cmp++; if (bus.o_hazard_cnt !== 16'd0) begin n_bad++; $display("FAIL rst_hz got=%0d exp=0", bus.o_hazard_cnt); end
    rst = 1'b0;
    bus.i_req_valid = '0;
  endtask

  task automatic test_single_write();
    logic [DW-1:0] wd;
    wd = {16{8'hA5}};
    do_reset();
    bus.i_req_valid = 2'b01;
    bus.i_req_we    = 2'b01;
    bus.i_req_addr[AW-1:0]  = 11'h12A;
    bus.i_req_wdata[DW-1:0] = wd;
    bus.i_req_wmask[MW-1:0] = 8'hFF;
    #1;
    n_cmp++; if (bus.o_req_ready !== 2'b01) begin n_bad++; $display("FAIL wr_ready got=%b exp=01", bus.o_req_ready); end
    n_cmp++; if (bus.o_idle !== 1'b0) begin n_bad++; $display("FAIL wr_idle0 got=%b exp=0", bus.o_idle); end
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      bus.i_req_valid = '0;
      #1;
      if (k == 1) begin
        n_cmp++; if (bus.o_sramc_wren_q !== 1'b1) begin n_bad++; $display("FAIL wr_wren got=%b exp=1", bus.o_sramc_wren_q); end
        n_cmp++; if (bus.o_sramc_rden_q !== 1'b0) begin n_bad++; $display("FAIL wr_rden got=%b exp=0", bus.o_sramc_rden_q); end
        n_cmp++; if (bus.o_sramc_wdata_q !== wd) begin n_bad++; $display("FAIL wr_wdata got=%h exp=%h", bus.o_sramc_wdata_q, wd); end
        n_cmp++; if (bus.o_sramc_wmask_q !== 8'hFF) begin n_bad++; $display("FAIL wr_wmask got=%h exp=ff", bus.o_sramc_wmask_q); end
      end
      if (k == 2) begin
        n_cmp++; if (bus.o_sramc_wren_q !== 1'b0) begin n_bad++; $display("FAIL wr_wren2 got=%b exp=0", bus.o_sramc_wren_q); end
      end
      n_cmp++; if (bus.o_sramc_addr_q !== 11'h12A) begin n_bad++; $display("FAIL wr_addr k=%0d got=%h exp=12a", k, bus.o_sramc_addr_q); end
      n_cmp++; if (bus.o_idle !== (k > D)) begin n_bad++; $display("FAIL wr_idle k=%0d got=%b exp=%b", k, bus.o_idle, k > D); end
    end
  endtask

  task automatic test_alternate();
    int c0, c1;
    logic [N-1:0] exp;
    c0 = 0;
    c1 = 0;
    do_reset();
    bus.i_req_valid = 2'b11;
    bus.i_req_we    = 2'b11;
    for (int k = 0; k < 6; k++) begin
      #1;
      exp = (k % 2 == 0) ? 2'b01 : 2'b10;
      n_cmp++; if (bus.o_req_ready !== exp) begin n_bad++; $display("FAIL alt_ready k=%0d got=%b exp=%b", k, bus.o_req_ready, exp); end
      if (bus.o_req_ready === 2'b01) c0++;
      if (bus.o_req_ready === 2'b10) c1++;
      @(negedge clk);
    end
    bus.i_req_valid = '0;
    n_cmp++; if (c0 !== 3) begin n_bad++; $display("FAIL alt_cnt0 got=%0d exp=3", c0); end
    n_cmp++; if (c1 !== 3) begin n_bad++; $display("FAIL alt_cnt1 got=%0d exp=3", c1); end
  endtask

  task automatic test_back_to_back();
    int a;
    logic [N-1:0] exp;
    do_reset();
    bus.i_req_valid = 2'b10;
    bus.i_req_we    = 2'b00;
    bus.i_req_addr[2*AW-1:AW] = 11'd5;
    #1;
    a = cyc;
    n_cmp++; if (bus.o_req_ready !== 2'b10) begin n_bad++; $display("FAIL b2b_rdy1 got=%b exp=10", bus.o_req_ready); end
    @(negedge clk);
    bus.i_req_valid = 2'b01;
    bus.i_req_addr[AW-1:0] = 11'd9;
    #1;
    n_cmp++; if (bus.o_req_ready !== 2'b01) begin n_bad++; $display("FAIL b2b_rdy0 got=%b exp=01", bus.o_req_ready); end
    n_cmp++; if (bus.o_sramc_rden_q !== 1'b1 || bus.o_sramc_addr_q !== 11'd5) begin n_bad++; $display("FAIL b2b_iss1 got=%b/%h exp=1/005", bus.o_sramc_rden_q, bus.o_sramc_addr_q); end
    @(negedge clk);
    bus.i_req_valid = '0;
    #1;
    n_cmp++; if (bus.o_sramc_rden_q !== 1'b1 || bus.o_sramc_addr_q !== 11'd9) begin n_bad++; $display("FAIL b2b_iss2 got=%b/%h exp=1/009", bus.o_sramc_rden_q, bus.o_sramc_addr_q); end
    for (int k = 3; k <= 12; k++) begin
      @(negedge clk);
      #1;
      exp = (k == 9) ? 2'b10 : (k == 10) ? 2'b01 : 2'b00;
      n_cmp++; if (bus.o_rsp_valid !== exp) begin n_bad++; $display("FAIL b2b_rspv k=%0d got=%b exp=%b", k, bus.o_rsp_valid, exp); end
      if (k == 9 || k == 10) begin
        n_cmp++; if (bus.o_rsp_rdata !== hist[a+k-1]) begin n_bad++; $display("FAIL b2b_data k=%0d got=%h exp=%h", k, bus.o_rsp_rdata, hist[a+k-1]); end
      end
    end
  endtask

  task automatic test_hold();
    logic [15:0] exp_hz;
    do_reset();
    bus.i_hold      = 1'b1;
    bus.i_req_valid = 2'b01;
    bus.i_req_we    = 2'b01;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++; if (bus.o_req_ready !== 2'b00) begin n_bad++; $display("FAIL hold_ready k=%0d got=%b exp=00", k, bus.o_req_ready); end
      @(negedge clk);
    end
    bus.i_hold = 1'b0;
    #1;
    exp_hz = HZ_EN ? 16'd4 : 16'd0;
    n_cmp++; if (bus.o_req_ready !== 2'b01) begin n_bad++; $display("FAIL hold_grant got=%b exp=01", bus.o_req_ready); end
    n_cmp++; if (bus.o_hazard_cnt !== exp_hz) begin n_bad++; $display("FAIL hold_hz got=%0d exp=%0d", bus.o_hazard_cnt, exp_hz); end
    @(negedge clk);
    bus.i_req_valid = '0;
  endtask

  task automatic test_reset_midflight();
    do_reset();
    bus.i_req_valid = 2'b01;
    bus.i_req_we    = 2'b00;
    bus.i_req_addr[AW-1:0] = 11'd3;
    #1;
    n_cmp++; if (bus.o_req_ready !== 2'b01) begin n_bad++; $display("FAIL mid_ready got=%b exp=01", bus.o_req_ready); end
    @(negedge clk);
    bus.i_req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 4; k <= 14; k++) begin
      #1;
      n_cmp++; if (bus.o_rsp_valid !== 2'b00) begin n_bad++; $display("FAIL mid_rspv k=%0d got=%b exp=00", k, bus.o_rsp_valid); end
      @(negedge clk);
    end
    bus.i_req_valid = 2'b11;
    bus.i_req_we    = 2'b11;
    #1;
    n_cmp++; if (bus.o_req_ready !== 2'b01) begin n_bad++; $display("FAIL mid_ptr got=%b exp=01", bus.o_req_ready); end
    @(negedge clk);
    bus.i_req_valid = '0;
  endtask

  task automatic test_random();
    logic [N-1:0]  pend;
    logic [N-1:0]  pwe;
    logic [AW-1:0] paddr [N];
    logic [DW-1:0] pwdata [N];
    logic [MW-1:0] pwmask [N];
    logic [N-1:0]  g;
    logic          e_wren, e_rden;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_last;
    logic [MW-1:0] e_wmask;
    logic [N-1:0]  e_rv;
    logic [DW-1:0] e_rd;
    logic [15:0]   hz, e_hz;
    logic          e_idle;
    rsp_t          rq [$];
    int            m_ptr, last_acc, w, gi;
    pend = '0; pwe = '0;
    e_wren = 0; e_rden = 0; e_addr = '0; e_wdata = '0; e_wmask = '0;
    e_last = '0; hz = '0; m_ptr = N - 1; last_acc = -100;
    do_reset();
    for (int it = 0; it < 400; it++) begin
      for (int r = 0; r < N; r++) begin
        if (!pend[r] && $urandom_range(0, 1) == 1) begin
          pend[r]   = 1'b1;
          pwe[r]    = 1'($urandom_range(0, 1));
          paddr[r]  = AW'($urandom);
          pwdata[r] = {$urandom, $urandom, $urandom, $urandom};
          pwmask[r] = MW'($urandom);
        end
        bus.i_req_addr[r*AW +: AW]  = paddr[r];
        bus.i_req_wdata[r*DW +: DW] = pwdata[r];
        bus.i_req_wmask[r*MW +: MW] = pwmask[r];
      end
      bus.i_req_valid = pend;
      bus.i_req_we    = pwe;
      bus.i_hold      = ($urandom_range(0, 4) == 0);
      #1;
      w = cyc;
      g = bus.i_hold ? '0 : ref_pick(pend, m_ptr);
      e_rv = '0;
      e_rd = e_last;
      if (rq.size() > 0 && rq[0].due == w) begin
        e_rv = N'(1) << rq[0].id;
        e_rd = hist[w-1];
        e_last = e_rd;
        void'(rq.pop_front());
      end
      e_idle = (g == '0) && (w > last_acc + D);
      e_hz = HZ_EN ? hz : 16'd0;
      n_cmp++; if (bus.o_req_ready !== g) begin n_bad++; $display("FAIL rnd_ready w=%0d got=%b exp=%b", w, bus.o_req_ready, g); end
      n_cmp++; if (bus.o_sramc_wren_q !== e_wren || bus.o_sramc_rden_q !== e_rden) begin n_bad++; $display("FAIL rnd_en w=%0d got=%b%b exp=%b%b", w, bus.o_sramc_wren_q, bus.o_sramc_rden_q, e_wren, e_rden); end
      n_cmp++; if (bus.o_sramc_addr_q !== e_addr) begin n_bad++; $display("FAIL rnd_addr w=%0d got=%h exp=%h", w, bus.o_sramc_addr_q, e_addr); end
      n_cmp++; if (bus.o_sramc_wdata_q !== e_wdata) begin n_bad++; $display("FAIL rnd_wdata w=%0d got=%h exp=%h", w, bus.o_sramc_wdata_q, e_wdata); end
      n_cmp++; if (bus.o_sramc_wmask_q !== e_wmask) begin n_bad++; $display("FAIL rnd_wmask w=%0d got=%h exp=%h", w, bus.o_sramc_wmask_q, e_wmask); end
      n_cmp++; if (bus.o_rsp_valid !== e_rv) begin n_bad++; $display("FAIL rnd_rspv w=%0d got=%b exp=%b", w, bus.o_rsp_valid, e_rv); end
      n_cmp++; if (bus.o_rsp_rdata !== e_rd) begin n_bad++; $display("FAIL rnd_rdata w=%0d got=%h exp=%h", w, bus.o_rsp_rdata, e_rd); end
      n_cmp++; if (bus.o_idle !== e_idle) begin n_bad++; $display("FAIL rnd_idle w=%0d got=%b exp=%b", w, bus.o_idle, e_idle); end
      n_cmp++; if (bus.o_hazard_cnt !== e_hz) begin n_bad++; $display("FAIL rnd_hz w=%0d got=%0d exp=%0d", w, bus.o_hazard_cnt, e_hz); end
      if ((|pend) && bus.i_hold && hz != 16'hFFFF) hz = hz + 16'd1;
      e_wren = 1'b0;
      e_rden = 1'b0;
      if (g != '0) begin
        gi = 0;
        for (int r = 0; r < N; r++) if (g[r]) gi = r;
        m_ptr = gi;
        last_acc = w;
        e_wren = pwe[gi];
        e_rden = ~pwe[gi];
        e_addr = paddr[gi];
        e_wdata = pwdata[gi];
        e_wmask = pwmask[gi];
        if (!pwe[gi]) rq.push_back('{due: w + D + 1, id: gi});
        pend[gi] = 1'b0;
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_write();
    test_alternate();
    test_back_to_back();
    test_hold();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/quant_port_scheduler.md
Name: quant_port_scheduler

Overview:
- Shares the single quantized SRAMC write/read port between N_REQ requesters, e.g. the PE-array output drain and the DMA fill/readback engine.
- Drives the input side of quantization_wrapper.
- Issues at most one transaction per cycle, chosen by round-robin arbitration.
- Tracks every transaction through the fixed quantization pipeline and the SRAM read latency, and routes each returning read word to the requester that issued it.

Parameters:
- SRAMC_W, 128, SRAM data width
- ADRC_W, 11, SRAM address width
- SRAMC_N, 8, write-mask elements
- N_REQ, 2, number of requesters (2..8)
- PIPE_LAT, 6, cycles from quantization_wrapper input to its output
- SRAM_RD_LAT, 1, cycles from SRAM rden to rdata valid

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_hold  in  1  when 1, no new grants; in-flight transactions keep draining
- i_req_valid  in  N_REQ  request valid, one bit per requester
- o_req_ready  out  N_REQ  grant/accept, one-hot or zero
- i_req_we  in  N_REQ  1 = write, 0 = read
- i_req_addr  in  N_REQ*ADRC_W  per-requester address, packed
- i_req_wdata  in  N_REQ*SRAMC_W  per-requester write data, packed
- i_req_wmask  in  N_REQ*SRAMC_N  per-requester write mask, packed
- o_sramc_wdata_q  out  SRAMC_W  to quantization_wrapper
- o_sramc_addr_q  out  ADRC_W  to quantization_wrapper
- o_sramc_wren_q  out  1  to quantization_wrapper
- o_sramc_wmask_q  out  SRAMC_N  to quantization_wrapper
- o_sramc_rden_q  out  1  to quantization_wrapper
- i_sramc_rdata  in  SRAMC_W  SRAM read data
- o_rsp_valid  out  N_REQ  one-hot read-response strobe
- o_rsp_rdata  out  SRAMC_W  read-response data, shared by all requesters
- o_idle  out  1  no transaction in flight
- o_hazard_cnt  out  16  optional-feature counter (see Optional Feature)

Behaviour:
- Reset:
  - Every output is 0, except o_idle = 1.
  - The round-robin pointer resets to N_REQ-1, so requester 0 has top priority after reset.
  - The tag pipeline is cleared.
  - Reset asserted mid-operation drops all in-flight responses; no o_rsp_valid is produced for them.
- Arbitration (combinational, same cycle):
  - o_req_ready[r] = 1 for the first valid r, searching from pointer+1 with wrap-around.
  - o_req_ready is all-zero if i_hold = 1 or i_rst = 1.
  - Accept occurs when valid & ready.
  - The pointer updates to r only on accept.
  - Requesters must hold valid and payload stable until accepted.
- Issue (registered, latency 1):
  - An accept at cycle t drives o_sramc_* at t+1.
  - wren = we, rden = ~we, and addr/wdata/wmask come from the granted requester.
  - With no accept, wren = rden = 0; addr/wdata/wmask hold their last value.
- Tag pipeline:
  - Shift register of depth D = 1+PIPE_LAT+SRAM_RD_LAT, entries {vld, is_rd, id[$clog2(N_REQ)]}.
  - An entry is pushed every cycle: vld = accept.
- Read response:
  - When the tail entry is a valid read, o_rsp_valid[id] = 1 and o_rsp_rdata = i_sramc_rdata, both registered.
  - This lands D+1 cycles after the accept, i.e. 9 with defaults.
  - When no read response is due, o_rsp_rdata holds its last value.
- Back-to-back accepts give one response per cycle, in issue order. There is no reordering and no backpressure on responses.
- o_idle = 1 iff no tag entry is valid and there was no accept in the current cycle.
- Writes and reads share one ordered pipeline, so read-after-write hazards to the same address resolve naturally; no scoreboard is needed.

Optional Feature:
- Macro: QUANT_SCHED_HAZARD_CNT_EN.
- Defined: o_hazard_cnt is a 16-bit saturating count of cycles in which some i_req_valid = 1 but no accept happened because i_hold = 1. It clears on reset.
- Undefined: o_hazard_cnt is tied to 0 and the counter logic is absent.

Decomposition:
- Package quant_sched_pkg: tag_t struct {vld, is_rd, id}, constant TAG_DEPTH = 1+PIPE_LAT+SRAM_RD_LAT, and function rr_pick(valid, ptr).
- Sub-module quant_sched_rr_arb: a parameterised N-way round-robin arbiter with inputs req/ptr/en and a one-hot grant output.

Test Plan:
- Reset, then a single write from r0 (addr 0x12A, wdata 0xA5.., wmask 0xFF): o_sramc_wren_q = 1 exactly one cycle later; o_idle returns to 1 after 8 cycles.
- Both requesters valid continuously for 6 cycles: grants alternate r0, r1, r0, …; each requester gets 3 grants.
- Reads from r1 at addr 5 then r0 at addr 9, back-to-back: o_rsp_valid = 2'b10 at t+9, then 2'b01 at t+10, each carrying the matching i_sramc_rdata.
- i_hold = 1 for 4 cycles with r0 valid: no ready. With the macro defined, o_hazard_cnt = 4. The grant follows on the first cycle after hold drops.
- Reset asserted 3 cycles after a read accept: no o_rsp_valid ever fires, and the pointer returns to N_REQ-1.
